// File: rtl/generic_sram_byte_en_arbiter.sv
// Two-port arbiter in front of a single-port byte-enabled SRAM.
// Round-robin grant when idle, with optional lock ownership that is released by an idle timeout.
module generic_sram_byte_en_arbiter #(
    parameter int MEM_ADDR_BITS = 10,
    parameter int DATA_WIDTH    = 32,
    parameter int LOCK_TIMEOUT  = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req0,
    input  logic                     req1,
    input  logic                     lock0,
    input  logic                     lock1,
    input  logic [MEM_ADDR_BITS-1:0] addr0,
    input  logic [MEM_ADDR_BITS-1:0] addr1,
    input  logic                     we0,
    input  logic                     we1,
    input  logic [DATA_WIDTH/8-1:0]  be0,
    input  logic [DATA_WIDTH/8-1:0]  be1,
    input  logic [DATA_WIDTH-1:0]    wdata0,
    input  logic [DATA_WIDTH-1:0]    wdata1,
    output logic                     gnt0,
    output logic                     gnt1,
    output logic                     rvalid0,
    output logic                     rvalid1,
    output logic [DATA_WIDTH-1:0]    rdata0,
    output logic [DATA_WIDTH-1:0]    rdata1,
    output logic [MEM_ADDR_BITS-1:0] sram_addr,
    output logic                     sram_write_en,
    output logic                     sram_read_en,
    output logic [DATA_WIDTH/8-1:0]  sram_byte_en,
    output logic [DATA_WIDTH-1:0]    sram_write_data,
    input  logic [DATA_WIDTH-1:0]    sram_read_data
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t     state;
    logic       prio;
    logic [7:0] idle_cnt;
    logic       rd_pend;
    logic       rd_tag;
    logic       acc;
    logic       acc_we;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state)
            IDLE: begin
                gnt0 = req0 && (!req1 || !prio);
                gnt1 = req1 && (!req0 || prio);
            end
            OWN0:    gnt0 = req0;
            OWN1:    gnt1 = req1;
            default: ;
        endcase
    end

    assign acc    = gnt0 || gnt1;
    assign acc_we = gnt0 ? we0 : we1;

    // SRAM bus is zero whenever nobody holds a grant
    always_comb begin
        sram_addr       = '0;
        sram_write_en   = 1'b0;
        sram_read_en    = 1'b0;
        sram_byte_en    = '0;
        sram_write_data = '0;
        if (gnt0) begin
            sram_addr       = addr0;
            sram_write_en   = we0;
            sram_read_en    = !we0;
            sram_byte_en    = be0;
            sram_write_data = wdata0;
        end else if (gnt1) begin
            sram_addr       = addr1;
            sram_write_en   = we1;
            sram_read_en    = !we1;
            sram_byte_en    = be1;
            sram_write_data = wdata1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            prio     <= 1'b0;
            idle_cnt <= 8'd0;
            rd_pend  <= 1'b0;
            rd_tag   <= 1'b0;
        end else begin
            rd_pend <= acc && !acc_we;
            rd_tag  <= gnt1;
            if (acc) begin
                prio     <= gnt0;
                idle_cnt <= 8'd0;
                if (gnt0) state <= lock0 ? OWN0 : IDLE;
                else      state <= lock1 ? OWN1 : IDLE;
            end else if (state != IDLE) begin
                // owner is silent this cycle; release once the limit is hit
                if (idle_cnt == 8'(LOCK_TIMEOUT - 1)) begin
                    state    <= IDLE;
                    idle_cnt <= 8'd0;
                end else begin
                    idle_cnt <= idle_cnt + 8'd1;
                end
            end
        end
    end

    // rst_n gating keeps a read in flight from surfacing while reset is applied
    assign rvalid0 = rst_n && rd_pend && !rd_tag;
    assign rvalid1 = rst_n && rd_pend && rd_tag;
    assign rdata0  = rvalid0 ? sram_read_data : '0;
    assign rdata1  = rvalid1 ? sram_read_data : '0;

endmodule

// File: tb/tb_generic_sram_byte_en_arbiter.sv
// Bench for generic_sram_byte_en_arbiter: SRAM device model, reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_generic_sram_byte_en_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int LT = 15;

    logic          clk;
    logic          rst_n;
    logic          req0, req1, lock0, lock1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [BW-1:0] be0, be1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] sram_addr;
    logic          sram_write_en, sram_read_en;
    logic [BW-1:0] sram_byte_en;
    logic [DW-1:0] sram_write_data;
    logic [DW-1:0] sram_read_data;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    generic_sram_byte_en_arbiter #(.MEM_ADDR_BITS(AW), .DATA_WIDTH(DW), .LOCK_TIMEOUT(LT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .we0(we0), .we1(we1),
        .be0(be0), .be1(be1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .sram_addr(sram_addr), .sram_write_en(sram_write_en), .sram_read_en(sram_read_en),
        .sram_byte_en(sram_byte_en), .sram_write_data(sram_write_data),
        .sram_read_data(sram_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(int a);
        return 32'h5A00_0000 ^ (32'(a) * 32'h0001_9E37);
    endfunction

    // SRAM device: byte-enabled write, read data one cycle after the address
    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    initial begin
        sram_read_data = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = init_word(i);
            ref_mem[i] = init_word(i);
        end
    end
    always @(posedge clk) begin
        if (sram_write_en)
            for (int b = 0; b < BW; b++)
                if (sram_byte_en[b]) mem[sram_addr][8*b +: 8] <= sram_write_data[8*b +: 8];
        if (sram_read_en) sram_read_data <= mem[sram_addr];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: owner (-1 none), rotating priority, idle count, queue of one pending read
    int            m_own  = -1;
    int            m_prio = 0;
    int            m_idle = 0;
    bit            m_pend = 0;
    int            m_tag  = 0;
    logic [DW-1:0] m_pdata = '0;

    always @(negedge clk) begin
        int            g;
        bit            e0, e1, ev0, ev1;
        logic [AW-1:0] ga;
        logic          gwe, glk;
        logic [BW-1:0] gbe;
        logic [DW-1:0] gwd;
        if (chk_en) begin
            if (m_own < 0) begin
                e0 = req0 && (!req1 || m_prio == 0);
                e1 = req1 && !e0;
            end else begin
                e0 = (m_own == 0) && req0;
                e1 = (m_own == 1) && req1;
            end
            g   = e0 ? 0 : (e1 ? 1 : -1);
            ga  = (g == 0) ? addr0  : (g == 1) ? addr1  : '0;
            gwe = (g == 0) ? we0    : (g == 1) ? we1    : 1'b0;
            glk = (g == 0) ? lock0  : (g == 1) ? lock1  : 1'b0;
            gbe = (g == 0) ? be0    : (g == 1) ? be1    : '0;
            gwd = (g == 0) ? wdata0 : (g == 1) ? wdata1 : '0;
            ev0 = rst_n && m_pend && m_tag == 0;
            ev1 = rst_n && m_pend && m_tag == 1;
            chk("gnt0", 64'(gnt0), 64'(e0));
            chk("gnt1", 64'(gnt1), 64'(e1));
            chk("rvalid0", 64'(rvalid0), 64'(ev0));
            chk("rvalid1", 64'(rvalid1), 64'(ev1));
            chk("rdata0", 64'(rdata0), ev0 ? 64'(m_pdata) : 64'd0);
            chk("rdata1", 64'(rdata1), ev1 ? 64'(m_pdata) : 64'd0);
            chk("sram_addr", 64'(sram_addr), 64'(ga));
            chk("sram_write_en", 64'(sram_write_en), 64'(g >= 0 && gwe));
            chk("sram_read_en", 64'(sram_read_en), 64'(g >= 0 && !gwe));
            chk("sram_byte_en", 64'(sram_byte_en), 64'(gbe));
            chk("sram_write_data", 64'(sram_write_data), 64'(gwd));
            if (g >= 0 && gwe)
                for (int b = 0; b < BW; b++)
                    if (gbe[b]) ref_mem[ga][8*b +: 8] = gwd[8*b +: 8];
            if (!rst_n) begin
                m_own = -1; m_prio = 0; m_idle = 0; m_pend = 0;
            end else begin
                m_pend = (g >= 0) && !gwe;
                m_tag  = g;
                if (g >= 0 && !gwe) m_pdata = ref_mem[ga];
                if (g >= 0) begin
                    m_own  = glk ? g : -1;
                    m_prio = 1 - g;
                    m_idle = 0;
                end else if (m_own >= 0) begin
                    m_idle++;
                    if (m_idle >= LT) begin
                        m_own  = -1;
                        m_idle = 0;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask
    task automatic look();
        @(negedge clk); #1;
    endtask
    task automatic quiet();
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; be0 = '0; be1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    initial begin
        logic [DW-1:0] merged;
        rst_n = 0;
        quiet();
        step();
        chk_en = 1;
        look();
        chk("reset gnt0", 64'(gnt0), 64'd0);
        chk("reset rvalid0", 64'(rvalid0), 64'd0);
        chk("reset rdata1", 64'(rdata1), 64'd0);
        step();

        // both read at once: port 0 first, then port 1, rvalids trail by a cycle
        rst_n = 1; req0 = 1; req1 = 1; addr0 = 10'd5; addr1 = 10'd9;
        look();
        chk("rr c1 gnt0", 64'(gnt0), 64'd1);
        chk("rr c1 gnt1", 64'(gnt1), 64'd0);
        chk("rr c1 addr", 64'(sram_addr), 64'd5);
        step();
        req0 = 0;
        look();
        chk("rr c2 gnt1", 64'(gnt1), 64'd1);
        chk("rr c2 addr", 64'(sram_addr), 64'd9);
        chk("rr c2 rvalid0", 64'(rvalid0), 64'd1);
        chk("rr c2 rdata0", 64'(rdata0), 64'(init_word(5)));
        step();
        req1 = 0;
        look();
        chk("rr c3 rvalid1", 64'(rvalid1), 64'd1);
        chk("rr c3 rdata1", 64'(rdata1), 64'(init_word(9)));
        step();

        // lone requests granted at once; priority flips after each
        req0 = 1; addr0 = 10'd4;
        look(); chk("lone0 gnt0", 64'(gnt0), 64'd1); step();
        req0 = 0; req1 = 1; addr1 = 10'd6;
        look(); chk("lone1 gnt1", 64'(gnt1), 64'd1); step();
        req0 = 1;
        look(); chk("prio0 gnt0", 64'(gnt0), 64'd1); step();
        look(); chk("prio1 gnt1", 64'(gnt1), 64'd1); step();
        req1 = 0;
        look(); chk("lone0b gnt0", 64'(gnt0), 64'd1); step();

        // locked 4-beat write burst from port 1 while port 0 keeps asking
        req0 = 1; addr0 = 10'd3;
        req1 = 1; we1 = 1; addr1 = 10'd3; be1 = 4'b0011; wdata1 = 32'hAABBCCDD; lock1 = 1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) lock1 = 0;
            look();
            chk("burst gnt0", 64'(gnt0), 64'd0);
            chk("burst gnt1", 64'(gnt1), 64'd1);
            chk("burst wen", 64'(sram_write_en), 64'd1);
            chk("burst be", 64'(sram_byte_en), 64'h3);
            step();
        end
        req1 = 0; we1 = 0; be1 = '0; wdata1 = '0;
        look(); chk("after burst gnt0", 64'(gnt0), 64'd1); step();
        req0 = 0;
        merged = init_word(3);
        merged[15:0] = 16'hCCDD;
        look();
        chk("merged rvalid0", 64'(rvalid0), 64'd1);
        chk("merged rdata0", 64'(rdata0), 64'(merged));
        step();

        // lock with silent owner, released by the timeout
        req0 = 1; lock0 = 1; addr0 = 10'd2;
        look(); chk("lock0 gnt0", 64'(gnt0), 64'd1); step();
        req0 = 0; lock0 = 0; req1 = 1; addr1 = 10'd8;
        for (int k = 0; k < LT; k++) begin
            look(); chk("timeout hold gnt1", 64'(gnt1), 64'd0); step();
        end
        look(); chk("timeout gnt1", 64'(gnt1), 64'd1); step();
        req1 = 0;
        step();

        // reset right after a locked read kills the rvalid and the lock
        req0 = 1; lock0 = 1; addr0 = 10'd7;
        look(); chk("pre-reset gnt0", 64'(gnt0), 64'd1); step();
        quiet(); rst_n = 0;
        look();
        chk("reset rvalid0", 64'(rvalid0), 64'd0);
        chk("reset rdata0", 64'(rdata0), 64'd0);
        step();
        rst_n = 1; req1 = 1; addr1 = 10'd1;
        look(); chk("post-reset gnt1", 64'(gnt1), 64'd1); step();
        quiet();
        step();

        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(99) != 0);
            if (!rst_n) quiet();
            else begin
                req0 = $urandom_range(1); req1 = $urandom_range(1);
                lock0 = ($urandom_range(3) == 0); lock1 = ($urandom_range(3) == 0);
                we0 = $urandom_range(1); we1 = $urandom_range(1);
                addr0 = AW'($urandom_range(15)); addr1 = AW'($urandom_range(15));
                be0 = BW'($urandom); be1 = BW'($urandom);
                wdata0 = $urandom; wdata1 = $urandom;
            end
            step();
        end
        quiet(); rst_n = 1;
        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/generic_sram_byte_en_arbiter.md
GENERIC_SRAM_BYTE_EN_ARBITER -- requirements
Module: generic_sram_byte_en_arbiter

Interface
REQ-001 SHALL have parameter MEM_ADDR_BITS, default 10, the SRAM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the SRAM data width; DATA_WIDTH/8 byte lanes.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 15, the idle-owner release limit in cycles (1..255).
REQ-004 SHALL have these ports:
- clk  in  1  clock; one clock, all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req0/req1  in  1  access request, port 0/1.
- lock0/lock1  in  1  keep ownership after this access (burst/exclusive sequence).
- addr0/addr1  in  MEM_ADDR_BITS  word address.
- we0/we1  in  1  1 = write, 0 = read.
- be0/be1  in  DATA_WIDTH/8  byte enables.
- wdata0/wdata1  in  DATA_WIDTH  write data.
- gnt0/gnt1  out  1  access accepted this cycle.
- rvalid0/rvalid1  out  1  read data valid.
- rdata0/rdata1  out  DATA_WIDTH  read data.
- sram_addr  out  MEM_ADDR_BITS; sram_write_en  out  1; sram_read_en  out  1; sram_byte_en  out  DATA_WIDTH/8; sram_write_data  out  DATA_WIDTH.
- sram_read_data  in  DATA_WIDTH  valid one cycle after the address.

Function
REQ-005 SHALL implement states IDLE, OWN0, OWN1 in a registered state register, plus a 1-bit round-robin pointer prio.
REQ-006 In IDLE, gntN SHALL be combinational: a single requester is granted; if both request, port prio is granted and the other port sees gnt=0.
REQ-007 In OWNn, only port n SHALL be granted (gntn=reqn); the other port's gnt SHALL be 0 regardless of its req.
REQ-008 An access SHALL occur in the cycle where req&&gnt: sram_addr/byte_en/write_data come from the granted port; sram_write_en=we of the granted port; sram_read_en=granted&&!we.
REQ-009 With no grant, sram_write_en=0, sram_read_en=0, sram_byte_en=0, sram_addr=0, sram_write_data=0.
REQ-010 On an accepted access with lockN=1, next state SHALL be OWNN; with lockN=0, next state SHALL be IDLE.
REQ-011 On every accepted access, prio SHALL be set to the non-granted port.
REQ-012 A port releasing ownership SHALL NOT hand the SRAM to the other port in the same cycle; the other port is grantable from the next cycle.
REQ-013 In OWNn, an 8-bit idle counter SHALL increment each cycle with reqn=0 and clear on any accepted access; on reaching LOCK_TIMEOUT, state SHALL go to IDLE next cycle and the counter SHALL clear.
REQ-014 Accepted reads SHALL be tracked by a registered pending bit and port tag; exactly one cycle later, rvalidN=1 for the tagged port and rdataN=sram_read_data.
REQ-015 rdata of a port without rvalid SHALL be 0; back-to-back reads SHALL yield back-to-back rvalid with no bubble.
REQ-016 A write SHALL never produce rvalid.

Reset
REQ-017 With rst_n=0 at a rising edge: state=IDLE, prio=0, idle counter=0, read pending=0; hence gnt0=gnt1=0 unless requested, rvalid0=rvalid1=0, rdata0=rdata1=0.
REQ-018 Reset asserted during OWNn or with a read pending SHALL drop ownership and suppress the pending rvalid.

Verification
REQ-019 Reset, both req=1, lock=0, reads addr0=5, addr1=9 -> cycle 1 gnt0=1, sram_addr=5; cycle 2 gnt1=1, sram_addr=9, rvalid0=1 with SRAM word 5; cycle 3 rvalid1=1.
REQ-020 Port 1 writes be1=4'b0011, wdata1=32'hAABBCCDD to addr 3 with lock1=1 for 4 beats while req0=1 -> gnt0=0 throughout, sram_write_en=1 for 4 cycles, gnt0=1 on the cycle after the lock1=0 beat.
REQ-021 Port 0 lock0=1 single access, then req0=0 for LOCK_TIMEOUT cycles -> state IDLE after timeout, req1 granted on the next cycle.
REQ-022 Alternating lone requests (port 0 only, then port 1 only) -> each granted immediately, prio toggles after each.
REQ-023 rst_n=0 one cycle after a port 0 read while in OWN0 -> no rvalid0, gnt1 available on the cycle after reset deasserts.
